// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
//  Module   : wb_stage
//  Purpose  : Writeback pipeline stage. Registers the memory-stage results,
//             extracts load data (byte/half/word/double, signed/unsigned),
//             selects the register-file write data and counts retired
//             instructions. rd_data_w doubles as the W->E forwarding value.
//  Ports    : clk, rst_n          - clock, asynchronous active-low reset
//             stall_w, flush_w    - hold stage / kill instruction entering W
//             *_m                 - memory-stage instruction fields
//             valid_w             - W slot holds a real instruction
//             rd_write_w, rd_w,
//             rd_data_w           - register-file write port
//             instret             - retired-instruction counter
//  Revision : 1.0 - initial release
// ============================================================================
module wb_stage #(
    parameter  int XLEN   = 32,
    parameter  int CNT_W  = 64,
    localparam int LANE_W = $clog2(XLEN/8)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall_w,
    input  logic              flush_w,
    input  logic              valid_m,
    input  logic              rd_write_m,
    input  logic [1:0]        rd_write_src_m,
    input  logic [4:0]        rd_m,
    input  logic [XLEN-1:0]   pc_m,
    input  logic [XLEN-1:0]   alu_res_m,
    input  logic [XLEN-1:0]   mem_read_data_m,
    input  logic [2:0]        mem_funct3_m,
    input  logic [LANE_W-1:0] mem_addr_lo_m,
    input  logic [XLEN-1:0]   csr_data_m,
    output logic              valid_w,
    output logic              rd_write_w,
    output logic [4:0]        rd_w,
    output logic [XLEN-1:0]   rd_data_w,
    output logic [CNT_W-1:0]  instret
);

    localparam logic [1:0]       c_SRC_ALU = 2'b00;
    localparam logic [1:0]       c_SRC_MEM = 2'b01;
    localparam logic [1:0]       c_SRC_PC4 = 2'b10;
    localparam logic [XLEN-1:0]  c_PC_INC  = XLEN'(4);
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);
    localparam bit               c_IS64    = (XLEN == 64);

    // Stage registers
    logic              r_valid;
    logic              r_rd_write;
    logic [1:0]        r_src;
    logic [4:0]        r_rd;
    logic [XLEN-1:0]   r_pc;
    logic [XLEN-1:0]   r_alu;
    logic [XLEN-1:0]   r_mem_data;
    logic [2:0]        r_funct3;
    logic [LANE_W-1:0] r_addr_lo;
    logic [XLEN-1:0]   r_csr;
    logic [CNT_W-1:0]  r_instret;

    logic [XLEN-1:0]   w_shifted;
    logic [XLEN-1:0]   w_word_s;
    logic [XLEN-1:0]   w_word_u;
    logic [XLEN-1:0]   w_load;
    logic [XLEN-1:0]   w_rd_data;
    logic              w_retire;

    // Flush wins over stall: the incoming slot is killed but its fields
    // still load so the W registers never carry stale data past a flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid    <= 1'b0;
            r_rd_write <= 1'b0;
            r_src      <= 2'b00;
            r_rd       <= 5'd0;
            r_pc       <= '0;
            r_alu      <= '0;
            r_mem_data <= '0;
            r_funct3   <= 3'b000;
            r_addr_lo  <= '0;
            r_csr      <= '0;
        end else if (flush_w || !stall_w) begin
            r_valid    <= valid_m & ~flush_w;
            r_rd_write <= rd_write_m;
            r_src      <= rd_write_src_m;
            r_rd       <= rd_m;
            r_pc       <= pc_m;
            r_alu      <= alu_res_m;
            r_mem_data <= mem_read_data_m;
            r_funct3   <= mem_funct3_m;
            r_addr_lo  <= mem_addr_lo_m;
            r_csr      <= csr_data_m;
        end
    end

    // An instruction retires when it leaves W: valid, not held, not flushed.
    assign w_retire = r_valid & ~stall_w & ~flush_w;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instret <= '0;
        end else if (w_retire) begin
            r_instret <= r_instret + c_CNT_ONE;
        end
    end

    // Bring the addressed byte lane down to bit 0; misaligned offsets simply
    // shift in zeros from the top.
    assign w_shifted = r_mem_data >> {r_addr_lo, 3'b000};

    // Word extraction only differs from the full datapath on RV64.
    generate
        if (XLEN == 64) begin : g_xlen64
            assign w_word_s = {{32{w_shifted[31]}}, w_shifted[31:0]};
            assign w_word_u = {32'b0, w_shifted[31:0]};
        end else begin : g_xlen32
            assign w_word_s = w_shifted;
            assign w_word_u = w_shifted;
        end
    endgenerate

    always_comb begin
        w_load = r_mem_data;
        case (r_funct3)
            3'b000:  w_load = {{(XLEN-8){w_shifted[7]}},   w_shifted[7:0]};
            3'b001:  w_load = {{(XLEN-16){w_shifted[15]}}, w_shifted[15:0]};
            3'b010:  w_load = w_word_s;
            3'b100:  w_load = {{(XLEN-8){1'b0}},  w_shifted[7:0]};
            3'b101:  w_load = {{(XLEN-16){1'b0}}, w_shifted[15:0]};
            3'b110: begin
                if (c_IS64) begin
                    w_load = w_word_u;
                end
            end
            // LD (011) and undefined encodings return the raw word.
            default: w_load = r_mem_data;
        endcase
    end

    always_comb begin
        w_rd_data = r_csr;
        case (r_src)
            c_SRC_ALU: w_rd_data = r_alu;
            c_SRC_MEM: w_rd_data = w_load;
            c_SRC_PC4: w_rd_data = r_pc + c_PC_INC;
            default:   w_rd_data = r_csr;
        endcase
    end

    assign valid_w    = r_valid;
    assign rd_write_w = r_valid & r_rd_write & (r_rd != 5'd0);
    assign rd_w       = r_rd;
    assign rd_data_w  = w_rd_data;
    assign instret    = r_instret;

endmodule
`default_nettype wire

// File: tb/tb_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_stage
//  Purpose  : Self-checking bench for wb_stage. Three instances: XLEN=32 with
//             a 64-bit counter (main), XLEN=32 with a 4-bit counter (shares
//             the main stimulus) and XLEN=64 (own stimulus). Expected
//             writebacks are queued at issue and popped by monitors.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_wb_stage;

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [63:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall_w = 1'b0;
    logic        flush_w = 1'b0;

    // 32-bit stimulus (main and counter-width instances)
    logic        v = 1'b0, we = 1'b0;
    logic [1:0]  src = 2'b00;
    logic [4:0]  rd = 5'd0;
    logic [31:0] pc = '0, alu = '0, mem = '0, csr = '0;
    logic [2:0]  f3 = 3'b000;
    logic [1:0]  lo = 2'b00;

    // 64-bit stimulus
    logic        v64 = 1'b0, we64 = 1'b0;
    logic [1:0]  src64 = 2'b00;
    logic [4:0]  rd64 = 5'd0;
    logic [63:0] pc64 = '0, alu64 = '0, mem64 = '0, csr64 = '0;
    logic [2:0]  f364 = 3'b000;
    logic [2:0]  lo64 = 3'b000;

    logic        valid_w, rd_write_w;
    logic [4:0]  rd_w;
    logic [31:0] rd_data_w;
    logic [63:0] instret;

    logic        c4_valid, c4_we;
    logic [4:0]  c4_rd;
    logic [31:0] c4_data;
    logic [3:0]  c4_instret;

    logic        o64_valid, o64_we;
    logic [4:0]  o64_rd;
    logic [63:0] o64_data;
    logic [63:0] o64_instret;

    int checks = 0;
    int errors = 0;
    exp_t q32[$];
    exp_t q64[$];

    always #5 clk = ~clk;

    wb_stage #(.XLEN(32), .CNT_W(64)) dut (
        .clk(clk), .rst_n(rst_n), .stall_w(stall_w), .flush_w(flush_w),
        .valid_m(v), .rd_write_m(we), .rd_write_src_m(src), .rd_m(rd),
        .pc_m(pc), .alu_res_m(alu), .mem_read_data_m(mem),
        .mem_funct3_m(f3), .mem_addr_lo_m(lo), .csr_data_m(csr),
        .valid_w(valid_w), .rd_write_w(rd_write_w), .rd_w(rd_w),
        .rd_data_w(rd_data_w), .instret(instret)
    );

    wb_stage #(.XLEN(32), .CNT_W(4)) dut_c4 (
        .clk(clk), .rst_n(rst_n), .stall_w(stall_w), .flush_w(flush_w),
        .valid_m(v), .rd_write_m(we), .rd_write_src_m(src), .rd_m(rd),
        .pc_m(pc), .alu_res_m(alu), .mem_read_data_m(mem),
        .mem_funct3_m(f3), .mem_addr_lo_m(lo), .csr_data_m(csr),
        .valid_w(c4_valid), .rd_write_w(c4_we), .rd_w(c4_rd),
        .rd_data_w(c4_data), .instret(c4_instret)
    );

    wb_stage #(.XLEN(64), .CNT_W(64)) dut64 (
        .clk(clk), .rst_n(rst_n), .stall_w(stall_w), .flush_w(flush_w),
        .valid_m(v64), .rd_write_m(we64), .rd_write_src_m(src64), .rd_m(rd64),
        .pc_m(pc64), .alu_res_m(alu64), .mem_read_data_m(mem64),
        .mem_funct3_m(f364), .mem_addr_lo_m(lo64), .csr_data_m(csr64),
        .valid_w(o64_valid), .rd_write_w(o64_we), .rd_w(o64_rd),
        .rd_data_w(o64_data), .instret(o64_instret)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Issue one 32-bit M-stage slot and advance one clock.
    task automatic cyc(input logic iv, input logic iwe, input logic [1:0] isrc,
                       input logic [4:0] ird, input logic [31:0] ipc,
                       input logic [31:0] ialu, input logic [31:0] imem,
                       input logic [2:0] if3, input logic [1:0] ilo,
                       input logic [31:0] icsr, input logic ist, input logic ifl,
                       input logic ewe, input logic [31:0] edata);
        v = iv; we = iwe; src = isrc; rd = ird; pc = ipc; alu = ialu;
        mem = imem; f3 = if3; lo = ilo; csr = icsr;
        stall_w = ist; flush_w = ifl; v64 = 1'b0;
        if (iv && !ist && !ifl) q32.push_back('{ewe, ird, {32'b0, edata}});
        @(posedge clk); #1;
    endtask

    task automatic alu_op(input logic [4:0] ird, input logic [31:0] val, input logic ewe);
        cyc(1'b1, 1'b1, 2'b00, ird, 32'h100, val, 32'h0, 3'b000, 2'b00, 32'h0,
            1'b0, 1'b0, ewe, val);
    endtask

    task automatic load_op(input logic [4:0] ird, input logic [2:0] if3,
                           input logic [1:0] ilo, input logic [31:0] edata);
        cyc(1'b1, 1'b1, 2'b01, ird, 32'h200, 32'h0, 32'h80FF7F01, if3, ilo, 32'h0,
            1'b0, 1'b0, 1'b1, edata);
    endtask

    task automatic bubble();
        cyc(1'b0, 1'b0, 2'b00, 5'd0, 32'h0, 32'h0, 32'h0, 3'b000, 2'b00, 32'h0,
            1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic cyc64(input logic iv, input logic [2:0] if3, input logic [2:0] ilo,
                         input logic [63:0] edata);
        v = 1'b0; stall_w = 1'b0; flush_w = 1'b0;
        v64 = iv; we64 = 1'b1; src64 = 2'b01; rd64 = 5'd3; pc64 = 64'h0;
        alu64 = 64'h0; mem64 = 64'h89ABCDEF_00000000; f364 = if3; lo64 = ilo;
        csr64 = 64'h0;
        if (iv) q64.push_back('{1'b1, 5'd3, edata});
        @(posedge clk); #1;
    endtask

    // Monitors: a W instruction is presented once, on the cycle it leaves W.
    always @(negedge clk) begin
        if (rst_n && valid_w && (!stall_w || flush_w)) begin
            if (q32.size() == 0) begin
                checks++; errors++;
                $display("FAIL wb32_unexpected actual=rd%0d required=none", rd_w);
            end else begin
                exp_t e;
                e = q32.pop_front();
                chk("wb32_we",   {63'b0, rd_write_w}, {63'b0, e.we});
                chk("wb32_rd",   {59'b0, rd_w},       {59'b0, e.rd});
                chk("wb32_data", {32'b0, rd_data_w},  e.data);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && o64_valid && (!stall_w || flush_w)) begin
            if (q64.size() == 0) begin
                checks++; errors++;
                $display("FAIL wb64_unexpected actual=rd%0d required=none", o64_rd);
            end else begin
                exp_t e;
                e = q64.pop_front();
                chk("wb64_we",   {63'b0, o64_we}, {63'b0, e.we});
                chk("wb64_rd",   {59'b0, o64_rd}, {59'b0, e.rd});
                chk("wb64_data", o64_data,        e.data);
            end
        end
    end

    task automatic chk_reset(input string tag);
        chk({tag, "_valid"},   {63'b0, valid_w},    64'h0);
        chk({tag, "_we"},      {63'b0, rd_write_w}, 64'h0);
        chk({tag, "_rd"},      {59'b0, rd_w},       64'h0);
        chk({tag, "_data"},    {32'b0, rd_data_w},  64'h0);
        chk({tag, "_instret"}, instret,             64'h0);
        chk({tag, "_c4_inst"}, {60'b0, c4_instret}, 64'h0);
        chk({tag, "_64valid"}, {63'b0, o64_valid},  64'h0);
        chk({tag, "_64data"},  o64_data,            64'h0);
    endtask

    initial begin
        // Reset is asynchronous: outputs are already clear before any edge.
        #1;
        chk_reset("rst_async");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk_reset("rst");

        // ALU writeback and first retire
        alu_op(5'd5, 32'h1234, 1'b1);
        chk("alu_instret_w", instret, 64'd0);
        bubble();
        chk("alu_instret_ret", instret, 64'd1);

        // Load extraction from 0x80FF7F01
        load_op(5'd1, 3'b000, 2'd3, 32'hFFFFFF80);
        load_op(5'd2, 3'b100, 2'd1, 32'h0000007F);
        load_op(5'd3, 3'b001, 2'd2, 32'hFFFF80FF);
        load_op(5'd4, 3'b101, 2'd0, 32'h00007F01);
        load_op(5'd5, 3'b010, 2'd0, 32'h80FF7F01);

        // JAL wraps, CSR value must not follow the changed M input
        cyc(1'b1, 1'b1, 2'b10, 5'd1, 32'hFFFFFFFC, 32'h0, 32'h0, 3'b000, 2'b00,
            32'h0, 1'b0, 1'b0, 1'b1, 32'h00000000);
        cyc(1'b1, 1'b1, 2'b11, 5'd2, 32'h0, 32'h0, 32'h0, 3'b000, 2'b00,
            32'hDEAD, 1'b0, 1'b0, 1'b1, 32'h0000DEAD);
        cyc(1'b0, 1'b1, 2'b11, 5'd9, 32'h40, 32'h0, 32'h0, 3'b000, 2'b00,
            32'hBEEF, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("csr_instret", instret, 64'd8);

        // Three stalled cycles with changing M inputs
        alu_op(5'd7, 32'h5555, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b1, 2'b00, 5'd9, 32'h0, 32'h9990 + i, 32'h0, 3'b000,
                2'b00, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0);
            chk("stall_data",    {32'b0, rd_data_w},  64'h5555);
            chk("stall_rd",      {59'b0, rd_w},       64'd7);
            chk("stall_valid",   {63'b0, valid_w},    64'd1);
            chk("stall_instret", instret,             64'd8);
        end
        bubble();
        chk("stall_release_instret", instret, 64'd9);

        // Flush together with stall kills the slot and does not count
        alu_op(5'd8, 32'h6666, 1'b1);
        cyc(1'b1, 1'b1, 2'b00, 5'd9, 32'h0, 32'h7777, 32'h0, 3'b000, 2'b00,
            32'h0, 1'b1, 1'b1, 1'b1, 32'h0);
        chk("flush_valid",   {63'b0, valid_w},    64'd0);
        chk("flush_we",      {63'b0, rd_write_w}, 64'd0);
        chk("flush_instret", instret,             64'd9);
        bubble();
        chk("flush_after_instret", instret, 64'd9);

        // Write to x0 is suppressed but still retires
        alu_op(5'd0, 32'hAAAA, 1'b0);
        chk("x0_valid", {63'b0, valid_w},    64'd1);
        chk("x0_we",    {63'b0, rd_write_w}, 64'd0);
        bubble();
        chk("x0_instret", instret, 64'd10);

        // Reach 17 retirements: the 4-bit counter wraps to 1
        for (int i = 0; i < 7; i++) alu_op(5'(10 + i), 32'(i), 1'b1);
        bubble();
        chk("cnt_instret", instret, 64'd17);
        chk("cnt4_wrap",   {60'b0, c4_instret}, 64'd1);

        // RV64 loads from 0x89ABCDEF_00000000
        cyc64(1'b1, 3'b110, 3'd4, 64'h00000000_89ABCDEF);
        cyc64(1'b1, 3'b010, 3'd4, 64'hFFFFFFFF_89ABCDEF);
        cyc64(1'b1, 3'b011, 3'd0, 64'h89ABCDEF_00000000);
        cyc64(1'b1, 3'b000, 3'd7, 64'hFFFFFFFF_FFFFFF89);
        cyc64(1'b0, 3'b000, 3'd0, 64'h0);
        chk("x64_instret", o64_instret, 64'd4);

        // Asynchronous reset in the middle of a valid instruction
        v = 1'b1; we = 1'b1; src = 2'b00; rd = 5'd5; alu = 32'h1234;
        stall_w = 1'b0; flush_w = 1'b0;
        @(posedge clk); #1;
        chk("pre_rst_valid", {63'b0, valid_w}, 64'd1);
        v = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk_reset("rst_mid");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        chk("q32_empty", 64'(q32.size()), 64'd0);
        chk("q64_empty", 64'(q64.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
